fc_argmax_classifier: RTL and testbench
=======================================

Name: fc_argmax_classifier

Overview:
- Final decision stage inside CNN_top. It consumes the serial stream of signed class scores from the last fully connected layer and produces the 4-bit `class` index that CNN_top drives out.
- Runs a running-max search over one frame of NUM_CLASS scores, then registers the winning index with a one-cycle valid pulse.
- Flags malformed frames (too short or too long).

Parameters:
- DATA_W, 16, width of each signed two's-complement score.
- NUM_CLASS, 10, scores per frame (MSTAR target classes); legal range 2..16.

Ports:
- clk_in  input  1  system clock, 100 MHz; all logic rising-edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all state immediately.
- score_valid  input  1  score_data is valid this cycle.
- score_data  input  DATA_W  signed score for the current class index.
- score_last  input  1  marks the final score of a frame; qualified by score_valid.
- class  output  4  index of the winning class; registered; held until the next frame completes.
- class_valid  output  1  one-cycle pulse when class updates.
- busy  output  1  high while a frame is in progress (ACC or DROP).
- err_len  output  1  one-cycle pulse, coincident with class_valid, when the frame length was not NUM_CLASS.

Behaviour:
- Reset values: class=0, class_valid=0, busy=0, err_len=0; FSM=IDLE; idx=0; max_val=0; max_idx=0.
- FSM states: IDLE, ACC, DROP, OUT.
- IDLE, on score_valid:
  - Load max_val=score_data, max_idx=0, idx=1.
  - If score_last is also high: go to OUT with short-frame error (NUM_CLASS is at least 2).
  - Otherwise: go to ACC.
- ACC, on score_valid:
  - Compare score_data against max_val as signed values.
  - If strictly greater: max_val=score_data, max_idx=idx.
  - Ties keep the lower index.
  - idx increments after each accepted score.
- ACC exit conditions:
  - score_last with idx==NUM_CLASS-1: go to OUT, no error.
  - score_last with idx<NUM_CLASS-1: go to OUT, err_len armed (short frame). The result is still max_idx over the scores received.
  - idx==NUM_CLASS-1 without score_last: the score is still compared, then go to DROP with err_len armed (long frame).
- DROP:
  - Discard all score_valid beats; max is frozen.
  - Leave for OUT on the first score_valid & score_last.
- OUT (single cycle):
  - class<=max_idx[3:0]; class_valid=1; err_len=armed flag; clear the armed flag.
  - Return to IDLE.
- Latency: class_valid asserts exactly 1 clk_in cycle after the cycle carrying score_last. For the long-frame case, this is measured from the terminating score_last.
- busy:
  - High from the cycle after the first accepted score through the cycle before OUT.
  - Low in IDLE and OUT.
- score_valid low in ACC or DROP: hold state; there is no timeout.
- score_valid during OUT: ignored. The upstream FC layer must leave one idle cycle between frames.
- score_last without score_valid: ignored.
- Arithmetic: signed DATA_W comparison only, with no extension or saturation needed. idx is a 4-bit counter and never wraps past NUM_CLASS-1.
- Reset mid-frame: all state clears asynchronously. The next score_valid after release starts a fresh frame. class returns to 0.

Test Plan:
- Normal frame: scores 3,-5,7,2,7,0,1,-1,6,4 (last on the 10th) -> class_valid pulse 1 cycle after the last beat, class=2 (tie at index 4 loses), err_len=0.
- All-negative frame with gaps: scores -100..-91 ascending (-100 at index 0), with score_valid deasserted for 3 cycles between beats 4 and 5 -> class=9, busy stays high through the gap, err_len=0.
- Short frame: 6 scores 0,0,9,0,0,0 with last on beat 6 -> class=2, err_len=1 together with class_valid.
- Long frame: 12 scores, where beat 10 (index 9) is the max 0x7FFF and beats 11-12 are 0x7FFF and 0x7FFE, last on beat 12 -> class=9, err_len=1, class_valid 1 cycle after beat 12.
- Reset mid-frame: assert rst_n=0 after 5 beats, release, then send a full frame with max at index 7 -> class=0 and no class_valid during reset, then class=7 with err_len=0.
- Back-to-back frames one idle cycle apart: winners 1 then 8 -> two class_valid pulses; class holds 1 between them, then 8.

Source files
------------

// File: rtl/fc_argmax_classifier.sv
// Final CNN decision stage: running signed max over one frame of class scores,
// registered winning index with a one-cycle valid pulse and a frame-length error flag.
module fc_argmax_classifier #(
   parameter int DATA_W    = 16,
   parameter int NUM_CLASS = 10
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              score_valid,
   input  logic [DATA_W-1:0] score_data,
   input  logic              score_last,
   output logic [3:0]        class_idx,
   output logic              class_valid,
   output logic              busy,
   output logic              err_len
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;
   localparam logic [3:0] LAST_IDX = 4'(NUM_CLASS - 1);

   logic [1:0]               state;
   logic [3:0]               idx;
   logic [3:0]               max_idx;
   logic signed [DATA_W-1:0] max_val;
   logic                     err_arm;
   logic                     gt;

   // strict compare so ties keep the earlier (lower) index
   assign gt   = $signed(score_data) > max_val;
   assign busy = (state == S_ACC) || (state == S_DROP);

   // class_idx/class_valid are loaded on the edge that enters OUT, so the
   // pulse is visible during the OUT cycle, one cycle after score_last
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         max_idx     <= '0;
         max_val     <= '0;
         err_arm     <= 1'b0;
         class_idx   <= '0;
         class_valid <= 1'b0;
         err_len     <= 1'b0;
      end else begin
         class_valid <= 1'b0;
         err_len     <= 1'b0;
         case (state)
            S_IDLE: if (score_valid) begin
               max_val <= score_data;
               max_idx <= '0;
               idx     <= 4'd1;
               if (score_last) begin
                  state       <= S_OUT;
                  class_idx   <= '0;
                  class_valid <= 1'b1;
                  err_len     <= 1'b1;
                  err_arm     <= 1'b0;
               end else begin
                  state <= S_ACC;
               end
            end
            S_ACC: if (score_valid) begin
               if (gt) begin
                  max_val <= score_data;
                  max_idx <= idx;
               end
               if (score_last) begin
                  state       <= S_OUT;
                  class_idx   <= gt ? idx : max_idx;
                  class_valid <= 1'b1;
                  err_len     <= err_arm | (idx != LAST_IDX);
                  err_arm     <= 1'b0;
               end else if (idx == LAST_IDX) begin
                  state   <= S_DROP;
                  err_arm <= 1'b1;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            S_DROP: if (score_valid && score_last) begin
               state       <= S_OUT;
               class_idx   <= max_idx;
               class_valid <= 1'b1;
               err_len     <= err_arm;
               err_arm     <= 1'b0;
            end
            S_OUT:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Scoreboard bench for fc_argmax_classifier: expected class/err/cycle pushed on
// the terminating beat, popped and compared when class_valid pulses.
module tb_fc_argmax_classifier;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic        score_valid = 1'b0;
   logic [15:0] score_data  = '0;
   logic        score_last  = 1'b0;
   logic [3:0]  class_idx;
   logic        class_valid;
   logic        busy;
   logic        err_len;

   fc_argmax_classifier #(.DATA_W(16), .NUM_CLASS(10)) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .score_valid (score_valid),
      .score_data  (score_data),
      .score_last  (score_last),
      .class_idx   (class_idx),
      .class_valid (class_valid),
      .busy        (busy),
      .err_len     (err_len)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int cls;
      int err;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   fr[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(posedge clk_in) cyc <= cyc + 1;

   // monitor: outputs only move on posedge, so negedge sampling is race-free
   always @(negedge clk_in) begin
      if (!rst_n) begin
         chk("rst_cv", class_valid, 0);
      end else if (class_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_cv", class_valid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("class", class_idx, e.cls);
            chk("err_len", err_len, e.err);
            chk("latency", cyc, e.cyc);
         end
      end else begin
         chk("err_stray", err_len, 0);
      end
   end

   // drives fr[] as one frame; optional gap after beat index gap_after,
   // optional check that class_idx holds hold_cls while the frame streams in
   task automatic send_frame(input int gap_after, input int gap_len,
                             input int ecls, input int eerr, input int hold_cls);
      for (int i = 0; i < fr.size(); i++) begin
         @(negedge clk_in);
         if (hold_cls >= 0) chk("class_hold", class_idx, hold_cls);
         score_valid = 1'b1;
         score_data  = 16'(fr[i]);
         score_last  = (i == fr.size() - 1);
         if (score_last) sb.push_back('{cls: ecls, err: eerr, cyc: cyc + 1});
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk_in);
               score_valid = 1'b0;
               score_last  = (g == 0);  // last without valid must be ignored
               chk("busy_gap", busy, 1);
            end
         end
      end
      @(negedge clk_in);
      score_valid = 1'b0;
      score_last  = 1'b0;
      chk("busy_out", busy, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_in);
         score_valid = 1'b0;
         score_last  = 1'b0;
      end
   endtask

   initial begin
      idle(2);
      chk("rst_class", class_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_len, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      idle(2);

      // normal frame, tie at index 4 loses to index 2
      fr = '{3, -5, 7, 2, 7, 0, 1, -1, 6, 4};
      send_frame(-1, 0, 2, 0, -1);
      idle(2);

      // all negative, ascending, 3-cycle gap between beats 4 and 5
      fr = '{-100, -99, -98, -97, -96, -95, -94, -93, -92, -91};
      send_frame(3, 3, 9, 0, -1);
      idle(2);

      // short frame
      fr = '{0, 0, 9, 0, 0, 0};
      send_frame(-1, 0, 2, 1, -1);
      idle(2);

      // long frame: later max-valued beats land in DROP and are discarded
      fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767, 32767, 32766};
      send_frame(9, 1, 9, 1, -1);
      idle(2);

      // single-beat frame is short by definition
      fr = '{5};
      send_frame(-1, 0, 0, 1, -1);
      idle(1);

      fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767};
      send_frame(-1, 0, 9, 0, -1);
      idle(1);

      // reset mid-frame after 5 beats
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_in);
         score_valid = 1'b1;
         score_data  = 16'(i + 1);
         score_last  = 1'b0;
      end
      @(negedge clk_in);
      score_valid = 1'b0;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_class", class_idx, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cv", class_valid, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      fr = '{10, 10, 10, 10, 10, 10, 10, 50, 10, 10};
      send_frame(-1, 0, 7, 0, -1);
      idle(2);

      // back-to-back frames separated by a single idle cycle
      fr = '{0, 20, 5, 5, 5, 5, 5, 5, 5, 5};
      send_frame(-1, 0, 1, 0, -1);
      fr = '{1, 1, 1, 1, 1, 1, 1, 1, 30, 1};
      send_frame(-1, 0, 8, 0, 1);
      idle(1);
      chk("b2b_final", class_idx, 8);

      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
      chk("sb_drain", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
